// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types, sizing helper and result encoding for the sequential comparator.
package cmp_pkg;

    typedef enum logic {IDLE, COMPARE} state_t;

    localparam logic [1:0] RES_EQ = 2'd0;
    localparam logic [1:0] RES_GT = 2'd1;
    localparam logic [1:0] RES_LT = 2'd2;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// chunk_cmp: combinational unsigned compare of one W-bit chunk.
module chunk_cmp #(
    parameter int W = 4
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic         eq_o,
    output logic         gt_o
);

    assign eq_o = x_i == y_i;
    assign gt_o = x_i > y_i;

endmodule

// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: multi-cycle MSB-first magnitude compare, CHUNK bits per clock, early exit.
module seq_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    localparam int NCHUNK = ceil_div(WIDTH, CHUNK),
    localparam int CW = $clog2(NCHUNK + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic [CW-1:0]    cycles
);

    localparam int PW = NCHUNK * CHUNK;

    state_t        state_q;
    logic [PW-1:0] a_q, b_q, a_d, b_d;
    logic [CW-1:0] step_q, cycles_q;
    logic          busy_q, done_q, eq_q, gt_q, lt_q;
    logic          chunk_eq, chunk_gt, last;
    logic [1:0]    res;

    // Sign-bit flip (offset binary) makes a signed compare purely unsigned; zero pad at the LSB end.
    assign a_d = PW'(a ^ {signed_mode, {(WIDTH-1){1'b0}}}) << (PW - WIDTH);
    assign b_d = PW'(b ^ {signed_mode, {(WIDTH-1){1'b0}}}) << (PW - WIDTH);

    chunk_cmp #(.W(CHUNK)) u_chunk_cmp (
        .x_i  (a_q[PW-1 -: CHUNK]),
        .y_i  (b_q[PW-1 -: CHUNK]),
        .eq_o (chunk_eq),
        .gt_o (chunk_gt)
    );

    assign last = step_q == CW'(NCHUNK - 1);
    assign res  = chunk_eq ? RES_EQ : (chunk_gt ? RES_GT : RES_LT);

    // Operands shift left each step so the current chunk is always the top CHUNK bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            step_q   <= '0;
            cycles_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    step_q  <= '0;
                    busy_q  <= 1'b1;
                    state_q <= COMPARE;
                end
            end else if (res != RES_EQ || last) begin
                eq_q     <= res == RES_EQ;
                gt_q     <= res == RES_GT;
                lt_q     <= res == RES_LT;
                cycles_q <= step_q + 1'b1;
                done_q   <= 1'b1;
                busy_q   <= 1'b0;
                state_q  <= IDLE;
            end else begin
                a_q    <= a_q << CHUNK;
                b_q    <= b_q << CHUNK;
                step_q <= step_q + 1'b1;
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign a_eq_b = eq_q;
    assign a_gt_b = gt_q;
    assign a_lt_b = lt_q;
    assign cycles = cycles_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// tb_seq_mag_comparator: directed checks on three configurations (8/2, 5/2 padded, 8/8 single step).
module tb_seq_mag_comparator;

    localparam logic [2:0] EQ = 3'b100, GT = 3'b010, LT = 3'b001, NONE = 3'b000;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] st, sm, bz, dn, eqv, gtv, ltv;
    logic [2:0][7:0] av, bv;
    logic [2:0] c8;
    logic [1:0] c5;
    logic [0:0] c1;
    int n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    seq_mag_comparator #(.WIDTH(8), .CHUNK(2)) u8 (
        .clk(clk), .rst(rst), .start(st[0]), .signed_mode(sm[0]), .a(av[0]), .b(bv[0]),
        .busy(bz[0]), .done(dn[0]), .a_eq_b(eqv[0]), .a_gt_b(gtv[0]), .a_lt_b(ltv[0]), .cycles(c8)
    );
    seq_mag_comparator #(.WIDTH(5), .CHUNK(2)) u5 (
        .clk(clk), .rst(rst), .start(st[1]), .signed_mode(sm[1]), .a(av[1][4:0]), .b(bv[1][4:0]),
        .busy(bz[1]), .done(dn[1]), .a_eq_b(eqv[1]), .a_gt_b(gtv[1]), .a_lt_b(ltv[1]), .cycles(c5)
    );
    seq_mag_comparator #(.WIDTH(8), .CHUNK(8)) u1 (
        .clk(clk), .rst(rst), .start(st[2]), .signed_mode(sm[2]), .a(av[2]), .b(bv[2]),
        .busy(bz[2]), .done(dn[2]), .a_eq_b(eqv[2]), .a_gt_b(gtv[2]), .a_lt_b(ltv[2]), .cycles(c1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cyc(input int i);
        return i == 0 ? 32'(c8) : (i == 1 ? 32'(c5) : 32'(c1));
    endfunction

    function automatic logic [2:0] flags(input int i);
        return {eqv[i], gtv[i], ltv[i]};
    endfunction

    // Called at a negedge; returns at the next negedge with start dropped.
    task automatic launch(input int i, input logic s, input logic [7:0] x, input logic [7:0] y);
        st[i] = 1'b1;
        sm[i] = s;
        av[i] = x;
        bv[i] = y;
        @(negedge clk);
        st[i] = 1'b0;
    endtask

    task automatic finish(input int i, input string tag, input logic [2:0] ef, input int ec, input int el);
        int lat = 0;
        while (!dn[i] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, el);
        check({tag, " flags"}, flags(i), ef);
        check({tag, " cycles"}, cyc(i), ec);
    endtask

    task automatic cmp(input int i, input string tag, input logic s, input logic [7:0] x,
                       input logic [7:0] y, input logic [2:0] ef, input int ec);
        launch(i, s, x, y);
        finish(i, tag, ef, ec, ec);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        rst = 1'b1;
        st = '0;
        sm = '0;
        av = '0;
        bv = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset outputs %0d", i), {bz[i], dn[i], flags(i)}, 5'b0);
            check($sformatf("reset cycles %0d", i), cyc(i), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        cmp(0, "eq a5", 1'b0, 8'hA5, 8'hA5, EQ, 4);
        cmp(0, "u 80>7f", 1'b0, 8'h80, 8'h7F, GT, 1);
        cmp(0, "s 80<7f", 1'b1, 8'h80, 8'h7F, LT, 1);
        cmp(0, "u 12<13", 1'b0, 8'h12, 8'h13, LT, 4);

        launch(0, 1'b0, 8'hFF, 8'h00);
        check("b2b done drop", dn[0], 1'b0);
        check("b2b busy", bz[0], 1'b1);
        check("b2b flags held", flags(0), LT);
        finish(0, "b2b ff>00", GT, 1, 1);

        launch(0, 1'b0, 8'h12, 8'h13);
        st[0] = 1'b1;
        av[0] = 8'hFF;
        bv[0] = 8'h00;
        @(negedge clk);
        st[0] = 1'b0;
        finish(0, "busy ignore", LT, 4, 3);

        launch(0, 1'b0, 8'hA5, 8'hA5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", bz[0], 1'b0);
        check("abort flags", flags(0), NONE);
        check("abort cycles", cyc(0), 0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= dn[0];
        end
        check("abort no done", seen, 1'b0);

        cmp(1, "w5 1f>1e", 1'b0, 8'h1F, 8'h1E, GT, 3);
        cmp(1, "w5 s 10<0f", 1'b1, 8'h10, 8'h0F, LT, 1);
        cmp(1, "w5 eq", 1'b0, 8'h0A, 8'h0A, EQ, 3);

        cmp(2, "c8 eq", 1'b0, 8'h3C, 8'h3C, EQ, 1);
        cmp(2, "c8 u", 1'b0, 8'hFE, 8'h01, GT, 1);
        cmp(2, "c8 s", 1'b1, 8'hFE, 8'h01, LT, 1);

        for (int k = 0; k < 300; k++) begin
            int i, ec;
            logic s;
            logic [7:0] x, y, d;
            logic [2:0] ef;
            i = k < 200 ? 0 : 2;
            x = 8'($urandom);
            y = k % 7 == 0 ? x : 8'($urandom);
            s = 1'($urandom);
            ef = x == y ? EQ : ((s ? $signed(x) > $signed(y) : x > y) ? GT : LT);
            d = x ^ y;
            ec = i == 2 ? 1 : (d[7:6] != 0 ? 1 : (d[5:4] != 0 ? 2 : (d[3:2] != 0 ? 3 : 4)));
            cmp(i, $sformatf("rand %0d %h %h s%0d", k, x, y, s), s, x, y, ef, ec);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
